n_bit_register_with_tick: RTL and testbench

//   Parametrised WIDTH-bit universal register with a built-in clock-enable divider.

---
 rtl/n_bit_register_with_tick.sv | 107 ++++++++++
 tb/tb_n_bit_register_with_tick.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/n_bit_register_with_tick.sv
// WIDTH-bit universal register (load/shift/rotate/clear/increment) updated on
// every DIV-th enabled clock edge, with a one-cycle tick after each update.
module n_bit_register_with_tick #(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] In,
    input  logic             sin,
    output logic [WIDTH-1:0] Out,
    output logic             co,
    output logic             tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_INC  = 3'b111
    } mode_t;

    logic [CW-1:0]    r_div_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_co;
    logic             r_tick;
    logic             w_strobe;
    logic [WIDTH-1:0] w_next;
    logic             w_next_co;
    mode_t            w_mode;

    // With DIV=1 the compare is against 0, so the counter never leaves 0.
    assign w_strobe = run && (r_div_cnt == CW'(DIV - 1));
    assign w_mode   = mode_t'(mode);

    always_comb begin
        w_next    = r_out;
        w_next_co = 1'b0;
        case (w_mode)
            MODE_HOLD: begin
                w_next    = r_out;
                w_next_co = 1'b0;
            end
            MODE_LOAD: begin
                w_next    = In;
                w_next_co = 1'b0;
            end
            MODE_SHL: begin
                w_next    = {r_out[WIDTH-2:0], sin};
                w_next_co = r_out[WIDTH-1];
            end
            MODE_SHR: begin
                w_next    = {sin, r_out[WIDTH-1:1]};
                w_next_co = r_out[0];
            end
            MODE_ROL: begin
                w_next    = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
                w_next_co = r_out[WIDTH-1];
            end
            MODE_ROR: begin
                w_next    = {r_out[0], r_out[WIDTH-1:1]};
                w_next_co = r_out[0];
            end
            MODE_CLR: begin
                w_next    = '0;
                w_next_co = 1'b0;
            end
            MODE_INC: begin
                w_next    = r_out + WIDTH'(1);
                w_next_co = &r_out;
            end
            default: begin
                w_next    = r_out;
                w_next_co = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_cnt <= '0;
            r_out     <= '0;
            r_co      <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= w_strobe;
            if (run) begin
                r_div_cnt <= w_strobe ? '0 : r_div_cnt + CW'(1);
            end
            if (w_strobe) begin
                r_out <= w_next;
                r_co  <= w_next_co;
            end
        end
    end

    assign Out  = r_out;
    assign co   = r_co;
    assign tick = r_tick;
endmodule

// File: tb/tb_n_bit_register_with_tick.sv
// Bench for n_bit_register_with_tick: a DIV=4 and a DIV=1 instance share inputs
// and are compared every cycle against an arithmetic reference model.
module tb_n_bit_register_with_tick;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         run = 1'b0;
  logic [2:0]   mode = 3'b000;
  logic [W-1:0] in_v = '0;
  logic         sin = 1'b0;
  logic [W-1:0] out4, out1;
  logic         co4, co1, tick4, tick1;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state, index 0 = DIV 4, index 1 = DIV 1
  int div_of[2] = '{4, 1};
  int m_out[2];
  int m_co[2];
  int m_tick[2];
  int m_runs[2];

  always #5 clk = ~clk;

  n_bit_register_with_tick #(.WIDTH(W), .DIV(4)) dut4 (
    .clk(clk), .reset(reset), .run(run), .mode(mode), .In(in_v), .sin(sin),
    .Out(out4), .co(co4), .tick(tick4)
  );

  n_bit_register_with_tick #(.WIDTH(W), .DIV(1)) dut1 (
    .clk(clk), .reset(reset), .run(run), .mode(mode), .In(in_v), .sin(sin),
    .Out(out1), .co(co1), .tick(tick1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k] = 0; m_co[k] = 0; m_tick[k] = 0; m_runs[k] = 0;
    end
  endtask

  // one rising edge as the reference sees it
  task automatic model_edge();
    int o, mx;
    mx = 1 << W;
    for (int k = 0; k < 2; k++) begin
      m_tick[k] = 0;
      if (run) begin
        m_runs[k]++;
        if (m_runs[k] % div_of[k] == 0) begin
          o = m_out[k];
          m_tick[k] = 1;
          case (mode)
            3'd0: begin m_out[k] = o; m_co[k] = 0; end
            3'd1: begin m_out[k] = int'(in_v); m_co[k] = 0; end
            3'd2: begin m_out[k] = (o * 2 + int'(sin)) % mx; m_co[k] = o / (mx / 2); end
            3'd3: begin m_out[k] = o / 2 + int'(sin) * (mx / 2); m_co[k] = o % 2; end
            3'd4: begin m_out[k] = (o * 2) % mx + o / (mx / 2); m_co[k] = o / (mx / 2); end
            3'd5: begin m_out[k] = o / 2 + (o % 2) * (mx / 2); m_co[k] = o % 2; end
            3'd6: begin m_out[k] = 0; m_co[k] = 0; end
            default: begin m_out[k] = (o + 1) % mx; m_co[k] = (o == mx - 1) ? 1 : 0; end
          endcase
        end
      end
    end
  endtask

  task automatic check_all();
    check("out4", int'(out4), m_out[0]);
    check("co4", int'(co4), m_co[0]);
    check("tick4", int'(tick4), m_tick[0]);
    check("cnt4", int'(dut4.r_div_cnt), m_runs[0] % 4);
    check("out1", int'(out1), m_out[1]);
    check("co1", int'(co1), m_co[1]);
    check("tick1", int'(tick1), m_tick[1]);
  endtask

  // drive at posedge+1, clock one edge, sample at posedge+1
  task automatic cycle(input logic r, input logic [2:0] m, input logic [W-1:0] d, input logic s);
    run = r; mode = m; in_v = d; sin = s;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic upd4(input logic [2:0] m, input logic [W-1:0] d, input logic s);
    for (int i = 0; i < 4; i++) cycle(1'b1, m, d, s);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("rst_out", int'(out4), 0);
    check("rst_co", int'(co4), 0);
    check("rst_tick", int'(tick4), 0);
    check("rst_cnt", int'(dut4.r_div_cnt), 0);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #3 reset = 1'b0;
    #10;
    check_all();
    @(posedge clk);
    #1 reset = 1'b1;

    // T2: first update on the 4th edge, tick in cycle 5 only, period 4
    cycle(1'b1, 3'd1, 4'hA, 1'b0);
    check("t2_e1_out", int'(out4), 0);
    cycle(1'b1, 3'd1, 4'hA, 1'b0);
    cycle(1'b1, 3'd1, 4'hA, 1'b0);
    cycle(1'b1, 3'd1, 4'hA, 1'b0);
    check("t2_e4_out", int'(out4), 10);
    check("t2_e4_tick", int'(tick4), 1);
    cycle(1'b1, 3'd1, 4'hA, 1'b0);
    check("t2_e5_tick", int'(tick4), 0);
    cycle(1'b1, 3'd1, 4'hA, 1'b0);
    cycle(1'b1, 3'd1, 4'hA, 1'b0);
    cycle(1'b1, 3'd1, 4'hA, 1'b0);
    check("t2_e8_tick", int'(tick4), 1);

    // T1: async reset mid-count while Out=A
    cycle(1'b1, 3'd1, 4'hA, 1'b0);
    cycle(1'b1, 3'd1, 4'hA, 1'b0);
    run = 1'b0;
    do_reset();
    upd4(3'd1, 4'h9, 1'b0);
    check("t1_first_upd", int'(out4), 9);

    // T3
    upd4(3'd2, 4'h0, 1'b1);
    check("t3_shl_out", int'(out4), 3);
    check("t3_shl_co", int'(co4), 1);
    upd4(3'd3, 4'h0, 1'b0);
    check("t3_shr_out", int'(out4), 1);
    check("t3_shr_co", int'(co4), 1);

    // T4
    upd4(3'd5, 4'h0, 1'b0);
    check("t4_ror_out", int'(out4), 8);
    check("t4_ror_co", int'(co4), 1);
    upd4(3'd4, 4'h0, 1'b0);
    check("t4_rol_out", int'(out4), 1);
    check("t4_rol_co", int'(co4), 1);

    // T5: wrap, then plain increment, then clear
    upd4(3'd1, 4'hF, 1'b0);
    upd4(3'd7, 4'h0, 1'b0);
    check("t5_wrap_out", int'(out4), 0);
    check("t5_wrap_co", int'(co4), 1);
    upd4(3'd7, 4'h0, 1'b0);
    check("t5_inc_out", int'(out4), 1);
    check("t5_inc_co", int'(co4), 0);
    upd4(3'd6, 4'h0, 1'b0);
    check("t5_clr_out", int'(out4), 0);
    check("t5_clr_co", int'(co4), 0);

    // T6: freeze with div_cnt=2; mode changes while frozen are ignored
    upd4(3'd1, 4'h5, 1'b0);
    cycle(1'b1, 3'd7, 4'h0, 1'b0);
    cycle(1'b1, 3'd7, 4'h0, 1'b0);
    check("t6_cnt2", int'(dut4.r_div_cnt), 2);
    for (int i = 0; i < 10; i++) cycle(1'b0, 3'(i % 8), 4'(i), 1'b1);
    check("t6_frozen_out", int'(out4), 5);
    cycle(1'b1, 3'd7, 4'h0, 1'b0);
    check("t6_resume1", int'(out4), 5);
    cycle(1'b1, 3'd7, 4'h0, 1'b0);
    check("t6_resume2", int'(out4), 6);

    // run drops exactly on the strobe cycle
    cycle(1'b1, 3'd7, 4'h0, 1'b0);
    cycle(1'b1, 3'd7, 4'h0, 1'b0);
    cycle(1'b1, 3'd7, 4'h0, 1'b0);
    cycle(1'b0, 3'd7, 4'h0, 1'b0);
    check("strobe_drop_cnt", int'(dut4.r_div_cnt), 3);
    cycle(1'b1, 3'd7, 4'h0, 1'b0);
    check("strobe_drop_upd", int'(out4), 7);

    // T7: DIV=1 ticks on every run edge
    for (int i = 0; i < 6; i++) cycle(1'b1, 3'd7, 4'h0, 1'b0);
    check("t7_tick1", int'(tick1), 1);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        run = 1'b0;
        do_reset();
      end
      cycle(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
            W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
